// File: rtl/pwm_bank_pkg.sv
// Shared types and helpers for the PWM bank: channel-count derivation
// and the default duty type of the PWM library.
package pwm_bank_pkg;

    localparam int PWM_WIDTH = 16;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    localparam duty_t DUTY_FULL = '1;

    function automatic int ch_count(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: pending/active duty pair with write-through on period
// wrap, and a registered compare/invert output.
module pwm_bank_channel
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wrap,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inv,
    output logic [WIDTH-1:0] pending,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] FULL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] active;
    logic             on_p0;

    // All-ones duty is full on; otherwise the output is on while cnt < duty
    assign on_p0 = (active == FULL) || (cnt < active);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (wr_en) begin
                pending <= wr_data;
            end
            // A write landing on the wrap cycle bypasses pending
            if (wrap) begin
                active <= wr_en ? wr_data : pending;
            end
        end
    end

    // ---- stage p1: registered output ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= inv;
        end else begin
            pwm_out <= on_p0 ^ inv;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler and period counter feeding
// 2**ADDR_BITS double-buffered channels, with registered readback.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int                        WIDTH         = 16,
    parameter int                        ADDR_BITS     = 2,
    parameter int                        PRESCALE_BITS = 8,
    parameter logic [2**ADDR_BITS-1:0]   INVERT_MASK   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_BITS-1:0]     wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [ADDR_BITS-1:0]     rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     period_start,
    output logic [2**ADDR_BITS-1:0]  pwm_out
);

    localparam int CH = ch_count(ADDR_BITS);

    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [WIDTH-1:0]         cnt;
    logic                     tick;
    logic                     wrap;
    logic [WIDTH-1:0]         pending [CH];

    // >= rather than == so lowering prescale never forces a long wrap
    assign tick = (pre_cnt >= prescale);
    assign wrap = tick && (cnt == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            period_start <= wrap;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_bank_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .cnt     (cnt),
            .wrap    (wrap),
            .wr_en   (wr_en && (wr_addr == ADDR_BITS'(i))),
            .wr_data (wr_data),
            .inv     (INVERT_MASK[i]),
            .pending (pending[i]),
            .pwm_out (pwm_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= pending[rd_addr];
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (WIDTH=4, two channels, channel 1 inverted).
module tb_pwm_bank;

    localparam int         W    = 4;
    localparam int         AB   = 1;
    localparam int         PB   = 8;
    localparam int         CH   = 2;
    localparam int         FULL = (1 << W) - 1;
    localparam logic [1:0] MASK = 2'b10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AB-1:0] rd_addr = '0;
    logic [PB-1:0] prescale = '0;
    logic [W-1:0]  rd_data;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_pre, m_cnt, m_ps, m_rd;
    int          m_pend [CH];
    int          m_act  [CH];
    logic [1:0]  m_pwm;

    typedef struct {
        logic [AB-1:0] wa;
        logic [W-1:0]  wd;
        logic [AB-1:0] ra;
        logic [W-1:0]  exp_rd;
    } rb_vec_t;

    rb_vec_t tbl [5];

    pwm_bank #(
        .WIDTH         (W),
        .ADDR_BITS     (AB),
        .PRESCALE_BITS (PB),
        .INVERT_MASK   (MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .prescale     (prescale),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_step();
        bit tick, wrap, on;
        if (reset) begin
            m_pre = 0; m_cnt = 0; m_ps = 0; m_rd = 0;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
            m_pwm = MASK;
        end else begin
            tick = (m_pre >= int'(prescale));
            wrap = tick && (m_cnt == FULL);
            for (int i = 0; i < CH; i++) begin
                on = (m_act[i] == FULL) || (m_cnt < m_act[i]);
                m_pwm[i] = on ^ MASK[i];
            end
            m_rd = m_pend[int'(rd_addr)];
            for (int i = 0; i < CH; i++) begin
                if (wrap) m_act[i] = (wr_en && int'(wr_addr) == i) ? int'(wr_data) : m_pend[i];
            end
            if (wr_en) m_pend[int'(wr_addr)] = int'(wr_data);
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) m_cnt = (m_cnt + 1) % (FULL + 1);
            m_ps = wrap ? 1 : 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("pwm_out", int'(pwm_out), int'(m_pwm));
        chk("period_start", int'(period_start), m_ps);
        chk("rd_data", int'(rd_data), m_rd);
    endtask

    task automatic wait_ps(input int limit);
        bit seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            cyc();
            if (period_start) seen = 1;
        end
        chk("ps_wait", int'(seen), 1);
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; wr_addr = AB'(a); wr_data = W'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        int first, nps, hi, lo, gap;

        tbl[0] = '{1'b0, 4'd5,  1'b0, 4'd5};
        tbl[1] = '{1'b1, 4'd9,  1'b1, 4'd9};
        tbl[2] = '{1'b0, 4'd12, 1'b1, 4'd9};
        tbl[3] = '{1'b1, 4'd0,  1'b0, 4'd12};
        tbl[4] = '{1'b1, 4'd15, 1'b1, 4'd15};

        // Reset state
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_pwm", int'(pwm_out), 2);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_rd", int'(rd_data), 0);

        // No writes: outputs idle, period_start every 16 cycles
        reset = 1'b0;
        first = -1; nps = 0;
        for (int k = 1; k <= 48; k++) begin
            cyc();
            if (period_start) begin
                nps++;
                if (first < 0) first = k;
            end
        end
        chk("first_ps", first, 16);
        chk("ps_count", nps, 3);

        // ch0=4 written mid-period
        repeat (5) cyc();
        write(0, 4);
        wait_ps(40);
        hi = 0; first = -1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (pwm_out[0]) begin
                hi++;
                if (first < 0) first = k;
            end
        end
        chk("duty4_high", hi, 4);
        chk("duty4_rise", first, 1);

        // ch1 (active-low) duty 0 then full
        write(1, 0);
        wait_ps(40);
        lo = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (!pwm_out[1]) lo++;
        end
        chk("ch1_duty0_active", lo, 0);
        write(1, 15);
        wait_ps(40);
        lo = 0; hi = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (!pwm_out[1]) lo++;
            if (pwm_out[0]) hi++;
        end
        chk("ch1_full_active", lo, 32);
        chk("ch0_unaffected", hi, 8);

        // Readback table
        foreach (tbl[i]) begin
            wr_en = 1'b1; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; rd_addr = tbl[i].ra;
            cyc();
            wr_en = 1'b0;
            cyc();
            chk($sformatf("readback%0d", i), int'(rd_data), int'(tbl[i].exp_rd));
        end

        // prescale=2: 48-cycle period, duty 8 -> 24 high cycles
        prescale = 8'd2;
        write(0, 8);
        wait_ps(200);
        hi = 0; gap = -1;
        for (int k = 1; k <= 48; k++) begin
            cyc();
            if (pwm_out[0]) hi++;
            if (period_start && gap < 0) gap = k;
        end
        chk("presc2_high", hi, 24);
        chk("presc2_period", gap, 48);

        // Lowering prescale below pre_cnt ticks on the next cycle
        prescale = 8'd6;
        wait_ps(400);
        repeat (5) cyc();
        prescale = 8'd2;
        gap = -1;
        for (int k = 1; k <= 400 && gap < 0; k++) begin
            cyc();
            if (period_start) gap = k;
        end
        chk("presc_lower_gap", gap, 46);

        // Write-through on the exact wrap cycle
        prescale = 8'd0;
        wait_ps(400);
        repeat (15) cyc();
        rd_addr = 1'b0;
        write(0, 10);
        chk("wt_ps", int'(period_start), 1);
        chk("wt_rd_old", int'(rd_data), 8);
        hi = pwm_out[0] ? 1 : 0;
        cyc();
        chk("wt_rd_new", int'(rd_data), 10);
        if (pwm_out[0]) hi++;
        for (int k = 3; k <= 16; k++) begin
            cyc();
            if (pwm_out[0]) hi++;
        end
        chk("wt_duty10_high", hi, 10);

        // Inverted ch1 duty 3, then reset while active
        write(1, 3);
        wait_ps(40);
        lo = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (!pwm_out[1]) lo++;
        end
        chk("inv_duty3_low", lo, 3);
        wait_ps(40);
        rd_addr = 1'b1;
        repeat (2) cyc();
        chk("inv_mid_active", int'(pwm_out[1]), 0);
        reset = 1'b1;
        cyc();
        chk("rst_mid_pwm", int'(pwm_out), 2);
        chk("rst_mid_rd", int'(rd_data), 0);
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (period_start && first < 0) first = k;
        end
        chk("rst_mid_first_ps", first, 16);

        // Randomised run against the model
        for (int k = 0; k < 3000; k++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = AB'($urandom);
            wr_data = W'($urandom);
            rd_addr = AB'($urandom);
            if (($urandom % 64) == 0) prescale = PB'($urandom % 4);
            reset   = ($urandom % 600) == 0;
            cyc();
        end
        reset = 1'b0;
        wr_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
